mips_cpu_hilo_muldiv: RTL and testbench
=======================================

Name: mips_cpu_hilo_muldiv

Overview:
- Multi-cycle multiply/divide unit and HI/LO register pair, alongside the combinational ALU on the execute stage.
- Takes the same rs/rt operand buses (A, B) as the ALU.
- Executes MULT, MULTU, DIV, DIVU iteratively and owns the architectural HI/LO registers.
- Control stalls on busy; MFHI/MFLO read hi/lo, which then route through the ALU PAS path.

Parameters:
- WIDTH, 32, operand and HI/LO width; iteration count equals WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- start  input  1  request strobe, sampled on rising edge.
- op  input  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO, 6/7=no-op.
- A  input  WIDTH  rs operand: multiplicand, dividend, or MTHI/MTLO source.
- B  input  WIDTH  rt operand: multiplier or divisor.
- busy  output  1  high while an arithmetic op is in flight.
- done  output  1  one-cycle pulse when HI/LO hold a new arithmetic result.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Reset: asynchronous, active-low, on reset_n low regardless of clk.
  - busy=0, done=0, hi=0, lo=0, state=IDLE, iteration counter=0, internal accumulators=0.
  - Reset mid-operation aborts the op; no partial result reaches hi/lo.
- FSM states: IDLE, RUN, FIX.
- IDLE, start=1 with op 0-3:
  - Latch A and B. For signed ops, latch magnitudes plus result-sign and remainder-sign flags.
  - Counter<=0; go to RUN; busy<=1.
- IDLE, start=1 with op 4 (MTHI): hi<=A at that edge; stay IDLE; no done; busy stays 0. Op 5 (MTLO) likewise writes lo<=A.
- IDLE, start=1 with op 6/7: no effect.
- RUN: one iteration per cycle, WIDTH cycles; counter increments 0..WIDTH-1. At counter=WIDTH-1, go to FIX.
  - Multiply: shift-add on magnitudes, 2*WIDTH-bit product.
  - Divide: restoring shift-subtract on magnitudes.
- FIX: apply sign correction and write the results, then go to IDLE with busy<=0 and done<=1.
  - Multiply: hi=product[2W-1:W], lo=product[W-1:0].
  - Divide: lo=quotient, hi=remainder.
  - Signed multiply: product negated if operand signs differ.
  - Signed divide: quotient truncates toward zero; remainder takes the dividend's sign.
- Latency: start sampled at edge E0. busy=1 after E0 through E(WIDTH+1). hi/lo update and done=1 after E(WIDTH+1), i.e. WIDTH+2 cycles after the start cycle. done clears on the next edge.
- start while busy=1 is ignored for all ops, including MTHI/MTLO. Control must hold the request until busy=0.
- Operand latching: A/B changes after E0 do not affect the in-flight op.
- Divide by zero (B=0, DIV or DIVU): lo=all-ones, hi=A as latched. Same latency, done pulses.
- DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0. No trap.
- MULTU/DIVU treat operands as unsigned. MULT/DIV treat them as two's complement.
- hi/lo hold their value at all times except on the writes above.
- Simultaneous done pulse and new start: in the done cycle the FSM is in IDLE, so a start sampled at that edge is accepted. Back-to-back ops therefore have a throughput of WIDTH+2 cycles.

Test Plan:
- Reset mid-RUN: MULT started, reset_n pulled low at cycle 10 → busy=0, done=0, hi=lo=0 immediately; no done pulse after release.
- MULTU A=0xFFFFFFFF B=0xFFFFFFFF → after 34 cycles done=1 for one cycle, hi=0xFFFFFFFE, lo=0x00000001; busy high for exactly 33 cycles.
- MULT A=-7 (0xFFFFFFF9) B=3 → hi=0xFFFFFFFF, lo=0xFFFFFFEB. Then DIV A=-7 B=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU A=100 B=0 → lo=0xFFFFFFFF, hi=100, done pulses at cycle 34. DIV A=0x80000000 B=0xFFFFFFFF → lo=0x80000000, hi=0.
- MTHI A=0x12345678 at idle → hi=0x12345678 next cycle, lo unchanged, done stays 0. MTLO issued while busy → ignored, lo takes only the arithmetic result.
- DIVU 7/2 with start held high through the done cycle, A/B switched to 9/4 after E0 → first result lo=3, hi=1 from 7/2. A second op starts at the done edge and yields lo=2, hi=1.

Source files
------------

// File: rtl/mips_cpu_hilo_muldiv.sv
// Iterative multiply/divide unit owning the architectural HI/LO pair.
// One shift-add or restoring shift-subtract step per cycle on operand magnitudes, then sign fix-up.
module mips_cpu_hilo_muldiv #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]  acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0]  acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0]  opnd_q, opnd_d;
  logic              is_div_q, is_div_d;
  logic              neg_res_q, neg_res_d;
  logic              neg_rem_q, neg_rem_d;
  logic              div0_q, div0_d;
  logic              done_q, done_d;
  logic [WIDTH-1:0]  hi_q, hi_d;
  logic [WIDTH-1:0]  lo_q, lo_d;

  // Operand magnitudes for the signed ops (MULT/DIV have op_i[0] clear)
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  assign a_neg = ~op_i[0] & a_i[WIDTH-1];
  assign b_neg = ~op_i[0] & b_i[WIDTH-1];
  assign a_mag = a_neg ? -a_i : a_i;
  assign b_mag = b_neg ? -b_i : b_i;

  // Multiply: acc_lo holds the remaining multiplier bits, product shifts right into it
  logic [WIDTH:0] mul_sum;
  assign mul_sum = {1'b0, acc_hi_q} + {1'b0, (acc_lo_q[0] ? opnd_q : {WIDTH{1'b0}})};

  // Divide: acc_hi is the partial remainder, acc_lo shifts dividend out and quotient in
  logic [WIDTH:0]   div_shift;
  logic [WIDTH-1:0] div_diff;
  assign div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
  assign div_diff  = div_shift[WIDTH-1:0] - opnd_q;

  logic [2*WIDTH-1:0] prod;
  assign prod = {acc_hi_q, acc_lo_q};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    opnd_d    = opnd_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    div0_d    = div0_q;
    done_d    = 1'b0;
    hi_d      = hi_q;
    lo_d      = lo_q;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          unique case (op_i)
            3'd0, 3'd1, 3'd2, 3'd3: begin
              acc_hi_d  = '0;
              acc_lo_d  = a_mag;
              opnd_d    = b_mag;
              cnt_d     = '0;
              is_div_d  = op_i[1];
              neg_res_d = a_neg ^ b_neg;
              neg_rem_d = a_neg;
              div0_d    = op_i[1] & (b_i == '0);
              state_d   = StRun;
            end
            3'd4:    hi_d = a_i;
            3'd5:    lo_d = a_i;
            default: ;
          endcase
        end
      end
      StRun: begin
        if (is_div_q) begin
          if (div_shift >= {1'b0, opnd_q}) begin
            acc_hi_d = div_diff;
            acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b1};
          end else begin
            acc_hi_d = div_shift[WIDTH-1:0];
            acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b0};
          end
        end else begin
          acc_hi_d = mul_sum[WIDTH:1];
          acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntW'(WIDTH - 1)) begin
          state_d = StFix;
        end
      end
      StFix: begin
        if (is_div_q) begin
          // Divide by zero leaves the all-ones quotient unnegated; remainder is then |A| re-signed
          lo_d = (neg_res_q && !div0_q) ? -acc_lo_q : acc_lo_q;
          hi_d = neg_rem_q ? -acc_hi_q : acc_hi_q;
        end else begin
          {hi_d, lo_d} = neg_res_q ? -prod : prod;
        end
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      opnd_q    <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      done_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      opnd_q    <= opnd_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      div0_q    <= div0_d;
      done_q    <= done_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign busy_o = (state_q != StIdle);
  assign done_o = done_q;
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule

// File: tb/tb_mips_cpu_hilo_muldiv.sv
// Bench for the HI/LO multiply/divide unit: directed vectors, corner sequences and a random
// run against a 64-bit arithmetic reference model.
module tb_mips_cpu_hilo_muldiv;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [2:0]    op;
  logic [W-1:0]  a, b;
  logic          busy, done;
  logic [W-1:0]  hi, lo;

  int n_vec = 0;
  int n_err = 0;

  mips_cpu_hilo_muldiv #(.WIDTH(W)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .start_i(start),
    .op_i   (op),
    .a_i    (a),
    .b_i    (b),
    .busy_o (busy),
    .done_o (done),
    .hi_o   (hi),
    .lo_o   (lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [2:0]   op;
    logic [31:0]  a;
    logic [31:0]  b;
    logic [31:0]  hi;
    logic [31:0]  lo;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic; SV division truncates toward zero, % follows dividend
  function automatic logic [63:0] ref_model(input logic [2:0] o, input logic [31:0] x,
                                            input logic [31:0] y);
    longint          sx = longint'($signed(x));
    longint          sy = longint'($signed(y));
    longint unsigned ux = {32'd0, x};
    longint unsigned uy = {32'd0, y};
    logic [63:0]     r;
    case (o)
      3'd0: r = sx * sy;
      3'd1: r = ux * uy;
      3'd2: r = (y == 0) ? {x, 32'hFFFF_FFFF} : {32'(sx % sy), 32'(sx / sy)};
      default: r = (y == 0) ? {x, 32'hFFFF_FFFF} : {32'(ux % uy), 32'(ux / uy)};
    endcase
    return r;
  endfunction

  // Wait from the current sample point until done, counting busy samples seen before it
  task automatic wait_done(input string name, output int k, output int busy_cnt);
    k = 0;
    busy_cnt = 0;
    while (!done && k < 100) begin
      if (busy) busy_cnt++;
      @(posedge clk); #1;
      k++;
    end
    if (!done) begin
      n_vec++;
      n_err++;
      $display("FAIL %s_timeout: got no done within %0d cycles, expected done", name, k);
    end
  endtask

  task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] ehi, input logic [31:0] elo);
    int k, bc;
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom;
    wait_done(name, k, bc);
    check({name, "_latency"}, 64'(k), 64'(W + 1));
    check({name, "_busy_cycles"}, 64'(bc), 64'(W + 1));
    check({name, "_busy_at_done"}, 64'(busy), 64'd0);
    check({name, "_hilo"}, {hi, lo}, {ehi, elo});
    @(posedge clk); #1;
    check({name, "_done_clears"}, 64'(done), 64'd0);
  endtask

  function automatic logic [31:0] rand_opnd();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      4: return -32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    vec_t vecs[8];
    int   k, bc, dcount;
    logic [63:0] e;

    vecs[0] = '{"multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[1] = '{"mult_m7x3", 3'd0, 32'hFFFF_FFF9, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFEB};
    vecs[2] = '{"div_m7d2",  3'd2, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3] = '{"divu_d0",   3'd3, 32'd100,       32'd0,         32'd100,       32'hFFFF_FFFF};
    vecs[4] = '{"div_ovf",   3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000};
    vecs[5] = '{"div_m7d0",  3'd2, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF};
    vecs[6] = '{"mult_min2", 3'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0};
    vecs[7] = '{"divu_7d2",  3'd3, 32'd7,         32'd2,         32'd1,         32'd3};

    rst_n = 1'b0; start = 1'b0; op = 3'd7; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", {busy, done, hi, lo}, '0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo);

    // MTHI at idle: hi updates next cycle, lo untouched, no done
    start = 1'b1; op = 3'd4; a = 32'h1234_5678;
    @(posedge clk); #1;
    start = 1'b0;
    check("mthi_hilo", {hi, lo}, {32'h1234_5678, 32'd3});
    check("mthi_flags", {62'd0, busy, done}, 64'd0);
    @(posedge clk); #1;
    check("mthi_no_done", 64'(done), 64'd0);

    // MTLO held during a MULT is ignored
    start = 1'b1; op = 3'd0; a = 32'd5; b = 32'd6;
    @(posedge clk); #1;
    op = 3'd5; a = 32'hDEAD_BEEF;
    repeat (4) @(posedge clk);
    #1;
    start = 1'b0;
    wait_done("mtlo_busy", k, bc);
    check("mtlo_busy_hilo", {hi, lo}, {32'd0, 32'd30});
    @(posedge clk); #1;
    check("mtlo_busy_after", {hi, lo}, {32'd0, 32'd30});

    // DIVU 7/2 with start held through the done cycle; operands change after E0
    start = 1'b1; op = 3'd3; a = 32'd7; b = 32'd2;
    @(posedge clk); #1;
    a = 32'd9; b = 32'd4;
    wait_done("hold_first", k, bc);
    check("hold_first_latency", 64'(k), 64'(W + 1));
    check("hold_first_hilo", {hi, lo}, {32'd1, 32'd3});
    @(posedge clk); #1;
    start = 1'b0;
    check("hold_second_busy", 64'(busy), 64'd1);
    wait_done("hold_second", k, bc);
    check("hold_second_latency", 64'(k), 64'(W + 1));
    check("hold_second_hilo", {hi, lo}, {32'd1, 32'd2});
    @(posedge clk); #1;

    // Reset mid-RUN: immediate clear, no done after release
    start = 1'b1; op = 3'd4; a = 32'hAAAA_5555;
    @(posedge clk); #1;
    start = 1'b1; op = 3'd0; a = 32'd1234; b = 32'd5678;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("reset_mid_run", {busy, done, hi, lo}, '0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    dcount = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done || busy) dcount++;
    end
    check("reset_no_done", 64'(dcount), 64'd0);
    check("reset_hilo_hold", {hi, lo}, '0);

    // Random ops against the reference model
    for (int i = 0; i < 40; i++) begin
      logic [2:0]  ro;
      logic [31:0] ra, rb;
      ro = 3'($urandom_range(0, 3));
      ra = rand_opnd();
      rb = rand_opnd();
      e  = ref_model(ro, ra, rb);
      run_op($sformatf("rand%0d_op%0d_%h_%h", i, ro, ra, rb), ro, ra, rb, e[63:32], e[31:0]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
